// File: rtl/approx_mult_err_monitor_if.sv
// Sample stream from the 8x8 approximate multiplier into the error monitor:
// operand pair plus the multiplier's approximate product, valid/ready handshake.
interface approx_mult_err_monitor_if #(
  parameter int OP_W   = 8,
  parameter int PROD_W = 2 * OP_W
);
  logic              valid;
  logic              ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [PROD_W-1:0] approx;

  modport master (output valid, a, b, approx, input ready);
  modport slave  (input valid, a, b, approx, output ready);
endinterface

// File: rtl/approx_mult_err_monitor.sv
// Error-metric collector for the approximate multiplier: per-sample exact product
// and error distance, accumulated into count / error count / ED sum / max ED per run.
module approx_mult_err_monitor #(
  parameter int OP_W   = 8,
  parameter int PROD_W = 16,
  parameter int CNT_W  = 17,
  parameter int SUM_W  = 33
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  input  logic                        clear,
  input  logic [CNT_W-1:0]            num_samples,
  approx_mult_err_monitor_if.slave    in_if,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            sample_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic [SUM_W-1:0]            sum_ed,
  output logic [PROD_W-1:0]           max_ed,
  output logic [OP_W-1:0]             first_err_a,
  output logic [OP_W-1:0]             first_err_b
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_next;

  logic             go;        // start accepted this cycle
  logic             done_set;  // entering DONE this cycle
  logic             accept;

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] acc_cnt;

  logic                    s1_valid;
  logic [OP_W-1:0]         s1_a, s1_b;
  logic [PROD_W-1:0]       s1_approx;
  logic [PROD_W-1:0]       s1_exact;

  logic                    s2_valid;
  logic [OP_W-1:0]         s2_a, s2_b;
  logic signed [PROD_W:0]  s2_diff;
  logic [PROD_W-1:0]       ed;

  assign in_if.ready = (state == ST_RUN) && (acc_cnt < target);
  assign accept      = in_if.valid & in_if.ready;
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, otherwise paths that
  // skip an assignment would infer latches.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    done_set   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          go = 1'b1;
          if (num_samples == '0) begin
            state_next = ST_DONE;
            done_set   = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept && (acc_cnt + CNT_ONE == target)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_next = ST_DONE;
          done_set   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // clear overrides any transition, including a simultaneous start
    if (clear) begin
      state_next = ST_IDLE;
      go         = 1'b0;
      done_set   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      target   <= '0;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= done_set;
      if (clear) begin
        acc_cnt  <= '0;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= accept;
        s2_valid <= s1_valid;
        if (go) begin
          target  <= num_samples;
          acc_cnt <= '0;
        end else if (accept) begin
          acc_cnt <= acc_cnt + CNT_ONE;
        end
      end
    end
  end

  assign s1_exact = PROD_W'(s1_a) * PROD_W'(s1_b);

  // NOTE: datapath registers carry no reset; s1_valid/s2_valid qualify them,
  // so their power-up contents are never observed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_a      <= in_if.a;
      s1_b      <= in_if.b;
      s1_approx <= in_if.approx;
    end
    if (s1_valid) begin
      s2_a    <= s1_a;
      s2_b    <= s1_b;
      s2_diff <= $signed({1'b0, s1_exact}) - $signed({1'b0, s1_approx});
    end
  end

  // |diff| <= 2^PROD_W - 1, so the magnitude always fits PROD_W bits
  assign ed = s2_diff[PROD_W] ? PROD_W'(-s2_diff) : PROD_W'(s2_diff);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_ed      <= '0;
      max_ed      <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else if (clear || go) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_ed      <= '0;
      max_ed      <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else if (s2_valid) begin
      sample_cnt <= sample_cnt + CNT_ONE;
      sum_ed     <= sum_ed + SUM_W'(ed);
      if (ed > max_ed) max_ed <= ed;
      if (ed != '0) begin
        err_cnt <= err_cnt + CNT_ONE;
        // err_cnt still zero means this is the run's first erroneous sample
        if (err_cnt == '0) begin
          first_err_a <= s2_a;
          first_err_b <= s2_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Scoreboard bench for approx_mult_err_monitor: expected running stats are pushed
// on every accepted sample and checked (value and timing) when sample_cnt advances.
module tb_approx_mult_err_monitor;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 17;
  localparam int SUM_W  = 33;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [SUM_W-1:0] sum_ed;
  logic [PROD_W-1:0] max_ed;
  logic [OP_W-1:0]  first_err_a, first_err_b;

  approx_mult_err_monitor_if #(.OP_W(OP_W), .PROD_W(PROD_W)) in_if ();

  approx_mult_err_monitor #(
    .OP_W(OP_W), .PROD_W(PROD_W), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .clear       (clear),
    .num_samples (num_samples),
    .in_if       (in_if.slave),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned       cnt;
    int unsigned       err;
    longint unsigned   sum;
    int unsigned       max;
    int unsigned       fa;
    int unsigned       fb;
    int                upd_cyc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  int unsigned     m_cnt, m_err, m_max, m_fa, m_fb;
  longint unsigned m_sum;

  function automatic void model_reset();
    m_cnt = 0; m_err = 0; m_max = 0; m_fa = 0; m_fb = 0; m_sum = 0;
  endfunction

  // Called at the negedge before the accepting edge; stats land two edges later.
  function automatic void model_accept(int a, int b, int ap);
    exp_t e;
    int ed;
    ed = a * b - ap;
    if (ed < 0) ed = -ed;
    m_cnt++;
    if (ed != 0) begin
      if (m_err == 0) begin
        m_fa = a;
        m_fb = b;
      end
      m_err++;
    end
    m_sum += longint'(ed);
    if (ed > int'(m_max)) m_max = ed;
    e.cnt = m_cnt; e.err = m_err; e.sum = m_sum; e.max = m_max;
    e.fa = m_fa; e.fb = m_fb; e.upd_cyc = cyc + 3;
    sb_q.push_back(e);
  endfunction

  int unsigned prev_cnt = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (sample_cnt != prev_cnt) begin
      if (sample_cnt == prev_cnt + 1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: sample_cnt=%0d but no sample pending", sample_cnt);
        end else begin
          e = sb_q.pop_front();
          if (sample_cnt !== e.cnt || err_cnt !== e.err || sum_ed !== e.sum ||
              max_ed !== e.max || first_err_a !== e.fa || first_err_b !== e.fb ||
              cyc != e.upd_cyc) begin
            failures++;
            $display("FAIL sb_stats: got cnt=%0d err=%0d sum=%0d max=%0d fa=%0d fb=%0d cyc=%0d, need cnt=%0d err=%0d sum=%0d max=%0d fa=%0d fb=%0d cyc=%0d",
                     sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, first_err_b, cyc,
                     e.cnt, e.err, e.sum, e.max, e.fa, e.fb, e.upd_cyc);
          end
        end
      end else if (sample_cnt != 0) begin
        checks++;
        failures++;
        $display("FAIL sb_jump: sample_cnt=%0d after %0d", sample_cnt, prev_cnt);
      end
    end else if (sb_q.size() != 0 && cyc > sb_q[0].upd_cyc) begin
      checks++;
      failures++;
      $display("FAIL sb_late: sample_cnt=%0d at cyc=%0d, need %0d by cyc=%0d",
               sample_cnt, cyc, sb_q[0].cnt, sb_q[0].upd_cyc);
      void'(sb_q.pop_front());
    end
    prev_cnt = sample_cnt;
  end

  task automatic step(output bit acc);
    @(negedge CLK);
    acc = in_if.valid && in_if.ready;
    if (acc) model_accept(int'(in_if.a), int'(in_if.b), int'(in_if.approx));
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(int n);
    bit acc;
    repeat (n) step(acc);
  endtask

  // Presents one sample and holds it until accepted; leaves in_valid high.
  task automatic send(int a, int b, int ap);
    bit acc;
    bit ok = 1'b0;
    in_if.valid  = 1'b1;
    in_if.a      = OP_W'(a);
    in_if.b      = OP_W'(b);
    in_if.approx = PROD_W'(ap);
    for (int i = 0; i < 20; i++) begin
      step(acc);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept: (%0d,%0d) accepted=0 required=1", a, b);
    end
  endtask

  task automatic do_start(int n);
    bit acc;
    num_samples = CNT_W'(n);
    start = 1'b1;
    model_reset();
    step(acc);
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int bound);
    bit acc;
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step(acc);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done: done=%b within %0d cycles, required 1", name, done, bound);
    end
    step(acc);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    in_if.valid = 1'b0; in_if.a = '0; in_if.b = '0; in_if.approx = '0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, first_err_b, in_if.ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d ready=%b, required all 0",
               busy, done, sample_cnt, err_cnt, sum_ed, max_ed, in_if.ready);
    end
    RST_N = 1'b1;
    idle(2);
    // reset in the middle of a run
    do_start(10);
    for (int i = 1; i <= 5; i++) send(i, 3, i * 3 + 1);
    in_if.valid = 1'b0;
    #2;
    RST_N = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if ({busy, done, sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, first_err_b, in_if.ready} !== '0) begin
      failures++;
      $display("FAIL reset_midrun: busy=%b cnt=%0d err=%0d sum=%0d max=%0d fa=%0d ready=%b, required all 0",
               busy, sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, in_if.ready);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle(1);
    do_start(1);
    send(6, 7, 40);
    in_if.valid = 1'b0;
    wait_done("reset_rerun", 20);
    checks++;
    if (sample_cnt !== 1 || err_cnt !== 1 || sum_ed !== 2 || first_err_a !== 6 || first_err_b !== 7) begin
      failures++;
      $display("FAIL reset_rerun_stats: cnt=%0d err=%0d sum=%0d fa=%0d fb=%0d, required 1 1 2 6 7",
               sample_cnt, err_cnt, sum_ed, first_err_a, first_err_b);
    end
  endtask

  task automatic test_exact();
    do_start(3);
    send(255, 255, 65025);
    send(3, 5, 15);
    send(0, 7, 0);
    in_if.valid = 1'b0;
    wait_done("exact", 20);
    checks++;
    if (sample_cnt !== 3 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0 ||
        first_err_a !== 0 || first_err_b !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL exact_stats: cnt=%0d err=%0d sum=%0d max=%0d fa=%0d fb=%0d busy=%b, required 3 0 0 0 0 0 0",
               sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, first_err_b, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_start(4);
    send(3, 5, 14);
    send(255, 255, 0);
    send(10, 10, 104);
    send(2, 2, 4);
    checks++;
    if (in_if.ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain: ready=%b busy=%b after last accept, required 0 1", in_if.ready, busy);
    end
    in_if.valid = 1'b0;
    wait_done("b2b", 20);
    checks++;
    if (sample_cnt !== 4 || err_cnt !== 3 || sum_ed !== 65030 || max_ed !== 65025 ||
        first_err_a !== 3 || first_err_b !== 5) begin
      failures++;
      $display("FAIL b2b_stats: cnt=%0d err=%0d sum=%0d max=%0d fa=%0d fb=%0d, required 4 3 65030 65025 3 5",
               sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, first_err_b);
    end
  endtask

  task automatic test_gaps();
    int pat[4] = '{1, 0, 1, 1};
    int naccept = 0;
    bit acc;
    do_start(2);
    for (int i = 0; i < 4; i++) begin
      in_if.valid  = pat[i][0];
      in_if.a      = OP_W'(i + 1);
      in_if.b      = OP_W'(9);
      in_if.approx = PROD_W'((i + 1) * 9 + 2);
      step(acc);
      if (acc) naccept++;
      if (naccept == 2 && i == 2) begin
        checks++;
        if (in_if.ready !== 1'b0) begin
          failures++;
          $display("FAIL gaps_ready: ready=%b after 2nd accept, required 0", in_if.ready);
        end
      end
    end
    in_if.valid = 1'b0;
    checks++;
    if (naccept != 2) begin
      failures++;
      $display("FAIL gaps_accepts: accepted=%0d required=2", naccept);
    end
    wait_done("gaps", 20);
    checks++;
    if (sample_cnt !== 2 || err_cnt !== 2 || sum_ed !== 4 || first_err_a !== 1 || first_err_b !== 9) begin
      failures++;
      $display("FAIL gaps_stats: cnt=%0d err=%0d sum=%0d fa=%0d fb=%0d, required 2 2 4 1 9",
               sample_cnt, err_cnt, sum_ed, first_err_a, first_err_b);
    end
  endtask

  task automatic test_boundary();
    int seen_done = 0;
    bit acc;
    // zero-length run from DONE
    do_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || in_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_run: done=%b busy=%b cnt=%0d err=%0d sum=%0d ready=%b, required 1 0 0 0 0 0",
               done, busy, sample_cnt, err_cnt, sum_ed, in_if.ready);
    end
    step(acc);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_run_pulse: done=%b required 0", done);
    end
    // start while running must not restart the run
    do_start(3);
    send(1, 1, 0);
    num_samples = CNT_W'(1);
    start = 1'b1;
    send(2, 2, 4);
    start = 1'b0;
    send(3, 3, 9);
    in_if.valid = 1'b0;
    wait_done("start_in_run", 20);
    checks++;
    if (sample_cnt !== 3 || err_cnt !== 1 || sum_ed !== 1 || first_err_a !== 1 || first_err_b !== 1) begin
      failures++;
      $display("FAIL start_in_run: cnt=%0d err=%0d sum=%0d fa=%0d fb=%0d, required 3 1 1 1 1",
               sample_cnt, err_cnt, sum_ed, first_err_a, first_err_b);
    end
    // clear while draining discards in-flight samples and suppresses done
    do_start(2);
    send(4, 4, 0);
    send(5, 5, 0);
    in_if.valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_pre: busy=%b ready=%b, required 1 0", busy, in_if.ready);
    end
    clear = 1'b1;
    sb_q.delete();
    step(acc);
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 ||
        max_ed !== 0 || first_err_a !== 0 || first_err_b !== 0) begin
      failures++;
      $display("FAIL clear_drain: busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d, required all 0",
               busy, done, sample_cnt, err_cnt, sum_ed, max_ed);
    end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || sample_cnt !== 0) seen_done++;
      step(acc);
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL clear_quiet: done/stats activity in %0d cycles after clear, required 0", seen_done);
    end
  endtask

  task automatic test_sweep();
    do_start(65536);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        send(a, b, (a & ~3) * b);
    in_if.valid = 1'b0;
    wait_done("sweep", 20);
    checks++;
    if (sample_cnt !== 17'h10000 || err_cnt !== 48960 || sum_ed !== 33'd12533760 ||
        max_ed !== 765 || first_err_a !== 1 || first_err_b !== 1) begin
      failures++;
      $display("FAIL sweep_stats: cnt=%0d err=%0d sum=%0d max=%0d fa=%0d fb=%0d, required 65536 48960 12533760 765 1 1",
               sample_cnt, err_cnt, sum_ed, max_ed, first_err_a, first_err_b);
    end
    checks++;
    if (err_cnt !== m_err || sum_ed !== m_sum) begin
      failures++;
      $display("FAIL sweep_model: err=%0d sum=%0d, model err=%0d sum=%0d", err_cnt, sum_ed, m_err, m_sum);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_exact();
    test_back_to_back();
    test_gaps();
    test_boundary();
    test_sweep();
    idle(4);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d samples never reflected in stats, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
